// File: rtl/maze_pkg.sv
// Shared MAZE mesh node definitions: field widths, packet layout, port indices.
package maze_pkg;

   localparam int PKT_TYPE_W = 2;
   localparam int NODE_ID_W  = 6;
   localparam int PKT_DATA_W = 8;

   // Requester / output port indices inside a node
   localparam int PORT_A = 0;
   localparam int PORT_N = 1;
   localparam int PORT_W = 2;
   localparam int PORT_S = 3;
   localparam int PORT_E = 4;

   typedef struct packed {
      logic [PKT_TYPE_W-1:0] ptype;
      logic                  qos;
      logic [NODE_ID_W-1:0]  src;
      logic [NODE_ID_W-1:0]  tgt;
      logic [PKT_DATA_W-1:0] data;
   } pkt_t;

   // Next index in a ring of n entries
   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/node_out_arbiter_if.sv
// Requester bundle plus registered output channel of one node output port.
interface node_out_arbiter_if
   import maze_pkg::*;
#(
   parameter int NREQ = 5,
   parameter int DW   = 8
);
   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]            req_vld;
   logic [NREQ-1:0]            req_rdy;
   logic [PKT_TYPE_W*NREQ-1:0] req_type;
   logic [NREQ-1:0]            req_qos;
   logic [NODE_ID_W*NREQ-1:0]  req_src;
   logic [NODE_ID_W*NREQ-1:0]  req_tgt;
   logic [DW*NREQ-1:0]         req_data;
   logic [NREQ-1:0]            port_en;

   logic                       out_vld;
   logic                       out_rdy;
   logic [PKT_TYPE_W-1:0]      out_type;
   logic                       out_qos;
   logic [NODE_ID_W-1:0]       out_src;
   logic [NODE_ID_W-1:0]       out_tgt;
   logic [DW-1:0]              out_data;
   logic [IW-1:0]              out_gid;
   logic                       starve_evt;

   // Environment side: requesters, fault masks and the downstream sink
   modport master (
      output req_vld, req_type, req_qos, req_src, req_tgt, req_data, port_en, out_rdy,
      input  req_rdy, out_vld, out_type, out_qos, out_src, out_tgt, out_data, out_gid,
             starve_evt
   );

   // Arbiter side
   modport slave (
      input  req_vld, req_type, req_qos, req_src, req_tgt, req_data, port_en, out_rdy,
      output req_rdy, out_vld, out_type, out_qos, out_src, out_tgt, out_data, out_gid,
             starve_evt
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit at or after ptr, wrapping.
module rr_pick #(
   parameter int NREQ = 5,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   int            pos;
   logic [IW-1:0] pos_idx;

   // Scan from ptr upward modulo NREQ and take the first requester found
   always_comb begin
      gnt     = '0;
      idx     = '0;
      any     = 1'b0;
      pos     = 0;
      pos_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         pos_idx = IW'(pos);
         if (!any && req[pos_idx]) begin
            any          = 1'b1;
            gnt[pos_idx] = 1'b1;
            idx          = pos_idx;
         end
      end
   end

endmodule

// File: rtl/node_out_arbiter.sv
// Per-output-port arbiter: QoS-first round robin with starvation promotion,
// fault masking and a registered single-beat valid/ready output.
module node_out_arbiter
   import maze_pkg::*;
#(
   parameter int NREQ       = 5,
   parameter int DW         = 8,
   parameter int STARVE_LIM = 8
) (
   input logic               clk,
   input logic               rst_n,
   node_out_arbiter_if.slave bus
);

   localparam int            IW    = $clog2(NREQ);
   localparam int            CW    = 8;
   localparam logic [CW-1:0] LIM_C = CW'(STARVE_LIM);

   typedef struct packed {
      logic [PKT_TYPE_W-1:0] ptype;
      logic                  qos;
      logic [NODE_ID_W-1:0]  src;
      logic [NODE_ID_W-1:0]  tgt;
      logic [DW-1:0]         data;
   } out_pkt_t;

   // Unpacked views of the flat requester buses
   logic [PKT_TYPE_W-1:0] type_a [NREQ];
   logic [NODE_ID_W-1:0]  src_a  [NREQ];
   logic [NODE_ID_W-1:0]  tgt_a  [NREQ];
   logic [DW-1:0]         data_a [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_split
      assign type_a[g] = bus.req_type[g*PKT_TYPE_W +: PKT_TYPE_W];
      assign src_a[g]  = bus.req_src[g*NODE_ID_W +: NODE_ID_W];
      assign tgt_a[g]  = bus.req_tgt[g*NODE_ID_W +: NODE_ID_W];
      assign data_a[g] = bus.req_data[g*DW +: DW];
   end

   out_pkt_t      pkt_q, pkt_d;
   logic          vld_q, vld_d;
   logic [IW-1:0] gid_q, gid_d;
   logic [IW-1:0] ptr_hi_q, ptr_hi_d;
   logic [IW-1:0] ptr_lo_q, ptr_lo_d;
   logic [CW-1:0] wait_q [NREQ];
   logic [CW-1:0] wait_d [NREQ];
   logic          starve_q, starve_d;

   logic [NREQ-1:0] elig, promo, hi;
   logic [NREQ-1:0] hi_gnt, lo_gnt, winner, grant;
   logic [IW-1:0]   hi_idx, lo_idx, win_idx;
   logic            hi_any, lo_any, load, gnt_any;

   // Classify requesters into eligible and high-priority (qos or promoted)
   always_comb begin
      elig  = bus.req_vld & bus.port_en;
      promo = '0;
      for (int i = 0; i < NREQ; i++) begin
         promo[i] = (wait_q[i] == LIM_C);
      end
      hi = elig & (bus.req_qos | promo);
   end

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_hi (
      .req (hi),
      .ptr (ptr_hi_q),
      .gnt (hi_gnt),
      .idx (hi_idx),
      .any (hi_any)
   );

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_lo (
      .req (elig),
      .ptr (ptr_lo_q),
      .gnt (lo_gnt),
      .idx (lo_idx),
      .any (lo_any)
   );

   // High class wins outright; grant only when the output register can load
   always_comb begin
      load    = !vld_q || bus.out_rdy;
      gnt_any = load && lo_any && rst_n;
      winner  = hi_any ? hi_gnt : lo_gnt;
      win_idx = hi_any ? hi_idx : lo_idx;
      grant   = winner & {NREQ{gnt_any}};
   end

   // Next state of output register, pointers and starvation counters
   always_comb begin
      pkt_d    = pkt_q;
      vld_d    = vld_q;
      gid_d    = gid_q;
      ptr_hi_d = ptr_hi_q;
      ptr_lo_d = ptr_lo_q;
      starve_d = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         wait_d[i] = wait_q[i];
      end

      if (load) begin
         if (gnt_any) begin
            pkt_d.ptype = type_a[win_idx];
            pkt_d.qos   = bus.req_qos[win_idx];
            pkt_d.src   = src_a[win_idx];
            pkt_d.tgt   = tgt_a[win_idx];
            pkt_d.data  = data_a[win_idx];
            vld_d       = 1'b1;
            gid_d       = win_idx;
            if (hi_any) ptr_hi_d = IW'(wrap_inc(int'(win_idx), NREQ));
            else        ptr_lo_d = IW'(wrap_inc(int'(win_idx), NREQ));
         end else begin
            vld_d = 1'b0;
         end
      end

      for (int i = 0; i < NREQ; i++) begin
         if (!elig[i] || grant[i]) begin
            wait_d[i] = '0;
         end else if (gnt_any && (wait_q[i] != LIM_C)) begin
            wait_d[i] = wait_q[i] + CW'(1);
            if (wait_q[i] == LIM_C - CW'(1)) starve_d = 1'b1;
         end
      end
   end

   // State registers; reset drops any pending output packet immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_q    <= '0;
         vld_q    <= 1'b0;
         gid_q    <= '0;
         ptr_hi_q <= '0;
         ptr_lo_q <= '0;
         starve_q <= 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            wait_q[i] <= '0;
         end
      end else begin
         pkt_q    <= pkt_d;
         vld_q    <= vld_d;
         gid_q    <= gid_d;
         ptr_hi_q <= ptr_hi_d;
         ptr_lo_q <= ptr_lo_d;
         starve_q <= starve_d;
         for (int i = 0; i < NREQ; i++) begin
            wait_q[i] <= wait_d[i];
         end
      end
   end

   assign bus.req_rdy    = grant;
   assign bus.out_vld    = vld_q;
   assign bus.out_type   = pkt_q.ptype;
   assign bus.out_qos    = pkt_q.qos;
   assign bus.out_src    = pkt_q.src;
   assign bus.out_tgt    = pkt_q.tgt;
   assign bus.out_data   = pkt_q.data;
   assign bus.out_gid    = gid_q;
   assign bus.starve_evt = starve_q;

endmodule

// File: tb/tb_node_out_arbiter.sv
// Directed, table-driven bench for node_out_arbiter.
module tb_node_out_arbiter;
   import maze_pkg::*;

   localparam int NREQ = 5;
   localparam int DW   = 8;
   localparam int LIM  = 8;

   logic clk = 1'b0;
   logic rst_n;

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   node_out_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

   node_out_arbiter #(.NREQ(NREQ), .DW(DW), .STARVE_LIM(LIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic       rst;
      logic [4:0] vld;
      logic [4:0] qos;
      logic [4:0] en;
      logic       ordy;
      logic [4:0] exp_rdy;
      logic       exp_ovld;
      logic [2:0] exp_gid;
      logic       exp_starve;
   } vec_t;

   vec_t vecs[$];
   int   vec_count   = 0;
   int   miscompares = 0;

   // Fixed per-requester packet contents
   logic [7:0] data_tab [NREQ] = '{8'h3C, 8'hA5, 8'h5A, 8'hC3, 8'h96};
   logic [5:0] tgt_tab  [NREQ] = '{6'h01, 6'h1B, 6'h22, 6'h0D, 6'h3F};
   logic [5:0] src_tab  [NREQ] = '{6'h09, 6'h12, 6'h24, 6'h2D, 6'h36};
   logic [1:0] type_tab [NREQ] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   localparam logic [4:0] ALL = 5'b11111;

   function automatic vec_t mk(input logic rst, input logic [4:0] vld, input logic [4:0] qos,
                               input logic [4:0] en, input logic ordy, input logic [4:0] exp_rdy,
                               input logic exp_ovld, input int exp_gid, input logic exp_starve);
      vec_t v;
      v.rst        = rst;
      v.vld        = vld;
      v.qos        = qos;
      v.en         = en;
      v.ordy       = ordy;
      v.exp_rdy    = exp_rdy;
      v.exp_ovld   = exp_ovld;
      v.exp_gid    = 3'(exp_gid);
      v.exp_starve = exp_starve;
      return v;
   endfunction

   function automatic logic [4:0] oh(input int i);
      return 5'(1 << i);
   endfunction

   // Drive one cycle's worth of inputs
   task automatic applyStimulus(input vec_t v);
      rst_n        = !v.rst;
      bus.req_vld  = v.vld;
      bus.req_qos  = v.qos;
      bus.port_en  = v.en;
      bus.out_rdy  = v.ordy;
   endtask

   // Compare one observed value against its expected value
   task automatic checkOutput(input string name, input int row, input logic [31:0] act,
                              input logic [31:0] exp);
      vec_count++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
      end
   endtask

   // Apply a row, check the combinational handshake, then the registered outputs
   task automatic runRow(input int r);
      vec_t v;
      v = vecs[r];
      applyStimulus(v);
      #2;
      checkOutput("req_rdy", r, 32'(bus.req_rdy), 32'(v.exp_rdy));
      @(posedge clk);
      #1;
      checkOutput("out_vld", r, 32'(bus.out_vld), 32'(v.exp_ovld));
      checkOutput("starve_evt", r, 32'(bus.starve_evt), 32'(v.exp_starve));
      if (v.rst || v.exp_ovld) begin
         checkOutput("out_gid", r, 32'(bus.out_gid), 32'(v.exp_gid));
      end
      if (v.exp_ovld) begin
         checkOutput("out_data", r, 32'(bus.out_data), 32'(data_tab[v.exp_gid]));
         checkOutput("out_tgt", r, 32'(bus.out_tgt), 32'(tgt_tab[v.exp_gid]));
         checkOutput("out_src", r, 32'(bus.out_src), 32'(src_tab[v.exp_gid]));
         checkOutput("out_type", r, 32'(bus.out_type), 32'(type_tab[v.exp_gid]));
         checkOutput("out_qos", r, 32'(bus.out_qos), 32'(v.qos[v.exp_gid]));
      end
   endtask

   initial begin
      int seq2 [9];
      int seq6 [6];
      seq2 = '{0, 1, -1, -1, -1, -1, 2, 3, 4};
      seq6 = '{0, 2, 3, 4, 0, 2};

      rst_n        = 1'b0;
      bus.req_vld  = '0;
      bus.req_qos  = '0;
      bus.port_en  = ALL;
      bus.out_rdy  = 1'b1;
      bus.req_data = {data_tab[4], data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
      bus.req_tgt  = {tgt_tab[4], tgt_tab[3], tgt_tab[2], tgt_tab[1], tgt_tab[0]};
      bus.req_src  = {src_tab[4], src_tab[3], src_tab[2], src_tab[1], src_tab[0]};
      bus.req_type = {type_tab[4], type_tab[3], type_tab[2], type_tab[1], type_tab[0]};

      // Reset state, with all requesters asserting valid
      vecs.push_back(mk(1, ALL, 5'b0, ALL, 1, 5'b0, 0, 0, 0));

      // Single requester N, then drain to idle
      vecs.push_back(mk(0, 5'b00010, 5'b0, ALL, 1, 5'b00010, 1, PORT_N, 0));
      vecs.push_back(mk(0, 5'b00000, 5'b0, ALL, 1, 5'b00000, 0, 0, 0));

      // All qos=0: round robin, with a 4-cycle back-pressure stall after N
      vecs.push_back(mk(1, ALL, 5'b0, ALL, 1, 5'b0, 0, 0, 0));
      foreach (seq2[k]) begin
         if (seq2[k] < 0) vecs.push_back(mk(0, ALL, 5'b0, ALL, 0, 5'b0, 1, PORT_N, 0));
         else             vecs.push_back(mk(0, ALL, 5'b0, ALL, 1, oh(seq2[k]), 1, seq2[k], 0));
      end
      vecs.push_back(mk(0, ALL, 5'b0, ALL, 1, oh(0), 1, 0, 0));
      vecs.push_back(mk(0, ALL, 5'b0, ALL, 1, oh(1), 1, 1, 0));

      // E high priority for 3 beats, then low-class round robin from 0
      vecs.push_back(mk(1, ALL, 5'b0, ALL, 1, 5'b0, 0, 0, 0));
      for (int k = 0; k < 3; k++) vecs.push_back(mk(0, ALL, 5'b10000, ALL, 1, oh(PORT_E), 1, PORT_E, 0));
      for (int k = 0; k < 5; k++) vecs.push_back(mk(0, ALL, 5'b00000, ALL, 1, oh(k), 1, k, 0));

      // Starvation: E qos=1 forever, A loses LIM times, gets promoted
      vecs.push_back(mk(1, ALL, 5'b0, ALL, 1, 5'b0, 0, 0, 0));
      for (int k = 0; k < LIM; k++)
         vecs.push_back(mk(0, 5'b10001, 5'b10000, ALL, 1, oh(PORT_E), 1, PORT_E, (k == LIM-1)));
      vecs.push_back(mk(0, 5'b10001, 5'b10000, ALL, 1, oh(PORT_A), 1, PORT_A, 0));
      vecs.push_back(mk(0, 5'b10001, 5'b10000, ALL, 1, oh(PORT_E), 1, PORT_E, 0));

      // N masked by port_en
      vecs.push_back(mk(1, ALL, 5'b0, ALL, 1, 5'b0, 0, 0, 0));
      foreach (seq6[k]) vecs.push_back(mk(0, ALL, 5'b0, 5'b11101, 1, oh(seq6[k]), 1, seq6[k], 0));

      @(posedge clk);
      #1;
      for (int r = 0; r < vecs.size(); r++) runRow(r);

      // Asynchronous reset in the middle of a transfer
      applyStimulus(mk(0, ALL, 5'b0, ALL, 1, 5'b0, 0, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst out_vld", -1, 32'(bus.out_vld), 32'd0);
      checkOutput("async_rst out_gid", -1, 32'(bus.out_gid), 32'd0);
      checkOutput("async_rst req_rdy", -1, 32'(bus.req_rdy), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #2;
      checkOutput("post_rst req_rdy", -1, 32'(bus.req_rdy), 32'(oh(0)));
      @(posedge clk);
      #1;
      checkOutput("post_rst out_vld", -1, 32'(bus.out_vld), 32'd1);
      checkOutput("post_rst out_gid", -1, 32'(bus.out_gid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
